// File: rtl/tss_pkg.sv
// Shared constants, header codes and FSM state type for the TSS byte-stream deserializer.
package tss_pkg;

    localparam int COM_WIDTH_DIV     = 96;
    localparam int TM_WIDTH_DIV      = 32;

    localparam int START_FRAME_BYTES = COM_WIDTH_DIV / 8 + 1;
    localparam int TM_FRAME_BYTES    = TM_WIDTH_DIV / 8 + 1;
    localparam int ABORT_FRAME_BYTES = 2;

    localparam int HEADER_WIDTH      = 8;
    // Sized for the longest frame; the final byte only ever fills its low nibble.
    localparam int COMMAND_WIDTH     = 8 * START_FRAME_BYTES;
    localparam int IDX_WIDTH         = $clog2(START_FRAME_BYTES);

    localparam logic [7:0] START_HEADER    = 8'h5A;
    localparam logic [7:0] STOP_HEADER     = 8'hC3;
    localparam logic [7:0] CONTINUE_HEADER = 8'h3C;
    localparam logic [7:0] ABORT_HEADER    = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2,
        DRAIN   = 2'd3
    } tss_state_e;

    // Frame length implied by a header byte; zero means the byte is not a header.
    function automatic logic [IDX_WIDTH-1:0] frame_bytes(input logic [7:0] hdr);
        case (hdr)
            START_HEADER:    frame_bytes = IDX_WIDTH'(START_FRAME_BYTES);
            STOP_HEADER:     frame_bytes = IDX_WIDTH'(TM_FRAME_BYTES);
            CONTINUE_HEADER: frame_bytes = IDX_WIDTH'(TM_FRAME_BYTES);
            ABORT_HEADER:    frame_bytes = IDX_WIDTH'(ABORT_FRAME_BYTES);
            default:         frame_bytes = '0;
        endcase
    endfunction

endpackage

// File: rtl/tss_deserializer.sv
// Assembles header-led byte frames into a wide command word and flags malformed frames.
// Define TSS_DESER_ERR_CNT_EN to build the saturating discarded-frame counter.
module tss_deserializer
    import tss_pkg::*;
(
    input  logic                     clk,
    input  logic                     arst,
    input  logic [7:0]               tss_axis_tdata,
    input  logic                     tss_axis_tvalid,
    output logic                     tss_axis_tready,
    input  logic                     tss_axis_tlast,
    output logic [COMMAND_WIDTH-1:0] command_o,
    output logic                     command_valid_o,
    output logic                     frame_err_o,
    output logic [15:0]              err_cnt_o
);

    // Handshake: a byte moves only in a cycle where tvalid and tready are both high;
    // tready is low only in EMIT, so the stream stalls for the single output cycle.

    tss_state_e               state, state_next;
    logic [IDX_WIDTH-1:0]     idx, idx_next;
    logic [IDX_WIDTH-1:0]     len, len_next;
    logic [COMMAND_WIDTH-1:0] shift, shift_next;
    logic                     xfer;
    logic                     cmd_load;
    logic                     err_set;
    logic                     last_byte;
    logic [IDX_WIDTH-1:0]     hdr_len;

    assign tss_axis_tready = (state != EMIT);
    assign xfer            = tss_axis_tvalid && tss_axis_tready;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        len_next   = len;
        shift_next = shift;
        cmd_load   = 1'b0;
        err_set    = 1'b0;
        hdr_len    = frame_bytes(tss_axis_tdata);
        last_byte  = (idx == len - IDX_WIDTH'(1));

        case (state)
            IDLE: begin
                if (xfer) begin
                    if (hdr_len != '0) begin
                        shift_next      = '0;
                        shift_next[7:0] = tss_axis_tdata;
                        len_next        = hdr_len;
                        idx_next        = IDX_WIDTH'(1);
                        if (!tss_axis_tlast) begin
                            state_next = COLLECT;
                        end else if (hdr_len == IDX_WIDTH'(1)) begin
                            cmd_load   = 1'b1;
                            state_next = EMIT;
                        end else begin
                            err_set    = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        err_set    = 1'b1;
                        state_next = tss_axis_tlast ? IDLE : DRAIN;
                    end
                end
            end

            COLLECT: begin
                if (xfer) begin
                    for (int b = 1; b < START_FRAME_BYTES; b++) begin
                        if (idx == IDX_WIDTH'(b)) begin
                            if (last_byte) begin
                                shift_next[8*b +: 8] = {4'h0, tss_axis_tdata[3:0]};
                            end else begin
                                shift_next[8*b +: 8] = tss_axis_tdata;
                            end
                        end
                    end
                    if (last_byte) begin
                        if (tss_axis_tlast) begin
                            cmd_load   = 1'b1;
                            state_next = EMIT;
                        end else begin
                            err_set    = 1'b1;
                            state_next = DRAIN;
                        end
                    end else if (tss_axis_tlast) begin
                        err_set    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + IDX_WIDTH'(1);
                    end
                end
            end

            EMIT: begin
                state_next = IDLE;
            end

            DRAIN: begin
                if (xfer && tss_axis_tlast) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state           <= IDLE;
            idx             <= '0;
            len             <= '0;
            shift           <= '0;
            command_o       <= '0;
            command_valid_o <= 1'b0;
            frame_err_o     <= 1'b0;
        end else begin
            state           <= state_next;
            idx             <= idx_next;
            len             <= len_next;
            shift           <= shift_next;
            command_valid_o <= cmd_load;
            frame_err_o     <= err_set;
            if (cmd_load) begin
                command_o <= shift_next;
            end
        end
    end

`ifdef TSS_DESER_ERR_CNT_EN
    logic [15:0] err_cnt;

    always_ff @(posedge clk) begin
        if (arst) begin
            err_cnt <= '0;
        end else if (err_set && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tss_deserializer.sv
// Directed bench for tss_deserializer: frame decoding, error frames, stalls and mid-frame reset.
module tb_tss_deserializer;
    import tss_pkg::*;

    logic                     clk = 1'b0;
    logic                     arst;
    logic [7:0]               tdata;
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic [COMMAND_WIDTH-1:0] command;
    logic                     command_valid;
    logic                     frame_err;
    logic [15:0]              err_cnt;

    tss_deserializer dut (
        .clk             (clk),
        .arst            (arst),
        .tss_axis_tdata  (tdata),
        .tss_axis_tvalid (tvalid),
        .tss_axis_tready (tready),
        .tss_axis_tlast  (tlast),
        .command_o       (command),
        .command_valid_o (command_valid),
        .frame_err_o     (frame_err),
        .err_cnt_o       (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Output monitor, sampled on the falling edge.
    int                       valid_cnt  = 0;
    int                       err_pulses = 0;
    int                       both_cnt   = 0;
    int                       valid_cyc  = -1;
    logic                     valid_ready = 1'b1;
    logic [COMMAND_WIDTH-1:0] last_cmd = '0;

    always @(negedge clk) begin
        if (command_valid) begin
            valid_cnt   <= valid_cnt + 1;
            valid_cyc   <= cyc;
            last_cmd    <= command;
            valid_ready <= tready;
        end
        if (frame_err) err_pulses <= err_pulses + 1;
        if (command_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    int          accepted = 0;
    int          timeouts = 0;
    int          acc_cyc  = 0;
    logic [15:0] exp_errs = '0;

    task automatic check(input string tag, input logic [COMMAND_WIDTH-1:0] obs,
                         input logic [COMMAND_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one byte and hold it until a handshake edge, bounded to 20 cycles.
    task automatic send(input logic [7:0] d, input logic l);
        int  n;
        bit  done;
        n      = 0;
        done   = 1'b0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        while (!done && n < 20) begin
            @(negedge clk);
            if (tready) begin
                @(posedge clk);
                #1;
                accepted++;
                acc_cyc = cyc;
                done    = 1'b1;
            end
            n++;
        end
        if (!done) timeouts++;
    endtask

    task automatic send_frame(input logic [7:0] b[$], input int last_idx, input bit gaps);
        for (int i = 0; i < b.size(); i++) begin
            send(b[i], (i == last_idx));
            if (gaps) begin
                tvalid = 1'b0;
                tlast  = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef TSS_DESER_ERR_CNT_EN
        return exp_errs;
`else
        return 16'h0000;
`endif
    endfunction

    logic [7:0] q[$];
    int         v0, e0, a0;

    initial begin
        arst   = 1'b1;
        tvalid = 1'b0;
        tdata  = 8'h00;
        tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        arst = 1'b0;
        @(negedge clk);
        check("rst_command", command, '0);
        check_int("rst_valid", int'(command_valid), 0);
        check_int("rst_err", int'(frame_err), 0);
        check_int("rst_err_cnt", int'(err_cnt), 0);
        check_int("rst_ready", int'(tready), 1);
        @(posedge clk);
        #1;

        // START frame: header, 0x01..0x0B, final 0xA5 (low nibble kept).
        v0 = valid_cnt; e0 = err_pulses; a0 = accepted;
        q = {};
        q.push_back(START_HEADER);
        for (int k = 1; k <= 11; k++) q.push_back(8'(k));
        q.push_back(8'hA5);
        send_frame(q, 12, 1'b0);
        check_int("start_pulses", valid_cnt - v0, 1);
        check_int("start_err", err_pulses - e0, 0);
        check_int("start_accepted", accepted - a0, 13);
        check("start_cmd", last_cmd, 104'h05_0B0A0908_07060504_0302015A);
        check_int("start_latency", valid_cyc, acc_cyc);
        check_int("emit_ready_low", int'(valid_ready), 0);
        repeat (5) @(posedge clk);
        #1;
        check("start_hold", command, 104'h05_0B0A0908_07060504_0302015A);

        // STOP frame with tvalid toggling, then the same frame gap-free.
        v0 = valid_cnt;
        q = {STOP_HEADER, 8'h11, 8'h22, 8'h33, 8'hF7};
        send_frame(q, 4, 1'b1);
        check_int("stop_gap_pulses", valid_cnt - v0, 1);
        check("stop_gap_cmd", last_cmd, 104'h07_332211C3);
        v0 = valid_cnt;
        send_frame(q, 4, 1'b0);
        check_int("stop_pulses", valid_cnt - v0, 1);
        check("stop_cmd", last_cmd, 104'h07_332211C3);

        // ABORT frame.
        v0 = valid_cnt;
        q = {ABORT_HEADER, 8'h00};
        send_frame(q, 1, 1'b0);
        check_int("abort_pulses", valid_cnt - v0, 1);
        check("abort_cmd", last_cmd, 104'hF0);

        // Unknown header: whole frame discarded.
        v0 = valid_cnt; e0 = err_pulses; a0 = accepted;
        q = {8'h00, 8'h01, 8'h02, 8'h03};
        send_frame(q, 3, 1'b0);
        exp_errs = exp_errs + 16'd1;
        check_int("badhdr_err", err_pulses - e0, 1);
        check_int("badhdr_pulses", valid_cnt - v0, 0);
        check_int("badhdr_accepted", accepted - a0, 4);
        check_int("badhdr_err_cnt", int'(err_cnt), int'(exp_cnt()));
        check("badhdr_hold", command, 104'hF0);

        // STOP frame ending early.
        v0 = valid_cnt; e0 = err_pulses;
        q = {STOP_HEADER, 8'h01, 8'h02, 8'h03};
        send_frame(q, 3, 1'b0);
        exp_errs = exp_errs + 16'd1;
        check_int("short_err", err_pulses - e0, 1);
        check_int("short_pulses", valid_cnt - v0, 0);

        // STOP frame overrunning its length, tlast two bytes late.
        v0 = valid_cnt; e0 = err_pulses; a0 = accepted;
        q = {STOP_HEADER, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(q, 6, 1'b0);
        exp_errs = exp_errs + 16'd1;
        check_int("long_err", err_pulses - e0, 1);
        check_int("long_pulses", valid_cnt - v0, 0);
        check_int("long_accepted", accepted - a0, 7);
        check_int("long_err_cnt", int'(err_cnt), int'(exp_cnt()));

        // Valid CONTINUE frame after the error frames.
        v0 = valid_cnt; e0 = err_pulses;
        q = {CONTINUE_HEADER, 8'hAA, 8'hBB, 8'hCC, 8'hDE};
        send_frame(q, 4, 1'b0);
        check_int("cont_pulses", valid_cnt - v0, 1);
        check_int("cont_err", err_pulses - e0, 0);
        check("cont_cmd", last_cmd, 104'h0E_CCBBAA3C);

        // Header byte alone with tlast, then an ABORT frame.
        v0 = valid_cnt; e0 = err_pulses;
        q = {START_HEADER};
        send_frame(q, 0, 1'b0);
        exp_errs = exp_errs + 16'd1;
        check_int("hdronly_err", err_pulses - e0, 1);
        check_int("hdronly_pulses", valid_cnt - v0, 0);
        q = {ABORT_HEADER, 8'h3F};
        send_frame(q, 1, 1'b0);
        check_int("abort2_pulses", valid_cnt - v0, 1);
        check("abort2_cmd", last_cmd, 104'h0F_F0);
        check_int("abort2_err_cnt", int'(err_cnt), int'(exp_cnt()));

        // Reset in the middle of a START frame.
        v0 = valid_cnt; e0 = err_pulses;
        send(START_HEADER, 1'b0);
        for (int k = 1; k <= 9; k++) send(8'(k), 1'b0);
        tvalid = 1'b0;
        arst   = 1'b1;
        @(posedge clk);
        #1;
        arst     = 1'b0;
        exp_errs = '0;
        @(negedge clk);
        check("midrst_command", command, '0);
        check_int("midrst_valid", int'(command_valid), 0);
        check_int("midrst_err", int'(frame_err), 0);
        check_int("midrst_err_cnt", int'(err_cnt), 0);
        check_int("midrst_ready", int'(tready), 1);
        repeat (3) @(posedge clk);
        #1;
        check_int("midrst_no_pulse", valid_cnt - v0, 0);
        check_int("midrst_no_err", err_pulses - e0, 0);

        q = {CONTINUE_HEADER, 8'h01, 8'h02, 8'h03, 8'hF9};
        send_frame(q, 4, 1'b0);
        check_int("postrst_pulses", valid_cnt - v0, 1);
        check("postrst_cmd", last_cmd, 104'h09_0302013C);

        check_int("never_both", both_cnt, 0);
        check_int("handshake_timeouts", timeouts, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tss_deserializer.md
TSS_DESERIALIZER -- requirements
Module: tss_deserializer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-002 SHALL have port arst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port tss_axis_tdata  input  8  received byte.
REQ-004 SHALL have port tss_axis_tvalid  input  1  byte valid.
REQ-005 SHALL have port tss_axis_tready  output  1  block accepts byte.
REQ-006 SHALL have port tss_axis_tlast  input  1  final byte of frame.
REQ-007 SHALL have port command_o  output  COMMAND_WIDTH  assembled frame, header in [HEADER_WIDTH-1:0].
REQ-008 SHALL have port command_valid_o  output  1  one-cycle pulse, command_o valid.
REQ-009 SHALL have port frame_err_o  output  1  one-cycle pulse, frame discarded.
REQ-010 SHALL have port err_cnt_o  output  16  discarded-frame count (see Configuration).

Function
REQ-011 Byte transfer SHALL occur only when tss_axis_tvalid && tss_axis_tready.
REQ-012 FSM states SHALL be IDLE, COLLECT, EMIT, DRAIN; tss_axis_tready=1 in IDLE/COLLECT/DRAIN, 0 in EMIT.
REQ-013 IDLE: on transfer, byte SHALL be checked against START/STOP/CONTINUE/ABORT_HEADER; match -> store at shift[7:0], set expected length, byte index=1, go COLLECT (or to EMIT if tlast and length check passes, never for valid lengths); no match -> frame_err, go DRAIN unless tlast (then stay IDLE).
REQ-014 Expected length SHALL be START_FRAME_BYTES for START, TM_FRAME_BYTES for STOP/CONTINUE, ABORT_FRAME_BYTES for ABORT.
REQ-015 COLLECT: byte k (k < length-1) SHALL be written to shift[8k+:8]; final byte k=length-1 SHALL write only its low nibble to shift[8k+:4], upper nibble ignored.
REQ-016 COLLECT: tlast on byte k=length-1 SHALL go EMIT; tlast on k<length-1 SHALL pulse frame_err_o, go IDLE; no tlast at k=length-1 SHALL pulse frame_err_o, go DRAIN.
REQ-017 Bits of shift beyond the last written bit SHALL be zero; shift SHALL be cleared on entering COLLECT from IDLE.
REQ-018 EMIT: command_o SHALL load shift and command_valid_o SHALL pulse for exactly one cycle, then IDLE; latency from accepted final byte to command_valid_o = 1 cycle.
REQ-019 command_o SHALL hold its value until the next EMIT.
REQ-020 DRAIN: bytes SHALL be accepted and discarded until a transfer with tlast, then IDLE.
REQ-021 Byte index SHALL saturate at length-1; no wrap.
REQ-022 frame_err_o and command_valid_o SHALL never assert in the same cycle.

Reset
REQ-023 arst SHALL force IDLE, byte index 0, shift 0, command_o 0, command_valid_o 0, frame_err_o 0, err_cnt_o 0; tss_axis_tready=1 from the first cycle after reset.
REQ-024 arst mid-frame SHALL abandon the frame with no command_valid_o or frame_err_o pulse; next byte is treated as a header.

Configuration
REQ-025 With TSS_DESER_ERR_CNT_EN defined, err_cnt_o SHALL increment on each frame_err_o pulse, saturating at 16'hFFFF.
REQ-026 Without TSS_DESER_ERR_CNT_EN, err_cnt_o SHALL be constant 0 and no counter logic SHALL be synthesised.

Structure
REQ-027 tss_pkg SHALL hold START_FRAME_BYTES = COM_WIDTH_DIV/8+1, TM_FRAME_BYTES = TM_WIDTH_DIV/8+1, ABORT_FRAME_BYTES = 2, the COM_WIDTH_DIV/TM_WIDTH_DIV constants, and the FSM state enum typedef.
REQ-028 Header constants and COMMAND_WIDTH/HEADER_WIDTH SHALL come from tss_pkg; no sub-module; single file.

Verification
REQ-029 START frame, bytes START_HEADER,0x01..,final 0xA5, tlast on byte START_FRAME_BYTES-1 -> one command_valid_o pulse 1 cycle later, command_o[7:0]=START_HEADER, final nibble = 0x5.
REQ-030 STOP frame, TM_FRAME_BYTES bytes, tvalid toggling every other cycle -> same command_o as gap-free run, one pulse.
REQ-031 ABORT_HEADER then 0x00 with tlast -> command_o = ABORT_HEADER zero-extended, one pulse.
REQ-032 Header 0x00 followed by 3 bytes, tlast on 3rd -> frame_err_o once, all 4 bytes accepted, no command_valid_o, err_cnt_o = 1 (macro on) / 0 (off).
REQ-033 STOP frame with tlast on byte 3 -> frame_err_o, IDLE; STOP frame without tlast at TM_FRAME_BYTES-1, tlast 2 bytes later -> frame_err_o, DRAIN, then IDLE; following valid frame decodes correctly.
REQ-034 arst asserted at byte 10 of a START frame -> all outputs 0 next cycle, no pulses; subsequent valid CONTINUE frame decodes correctly.
